// File: rtl/svr_pkg.sv
// -----------------------------------------------------------------------------
// svr_pkg
// Shared definitions for the pixel packer: CSI-2 data type codes, trailer flag
// bit positions, the frame-capture state enum and the trailer word builder.
// -----------------------------------------------------------------------------
package svr_pkg;

    localparam logic [5:0] DT_RAW8  = 6'h28;
    localparam logic [5:0] DT_RAW10 = 6'h2B;

    // Trailer word flag positions; bits [15:0] carry the line count.
    localparam int TRL_FRAME_OVF_BIT = 16;
    localparam int TRL_DT_ERR_BIT    = 17;
    localparam int TRL_LEN_ERR_BIT   = 18;
    localparam int TRL_TRUNC_BIT     = 19;

    typedef enum logic [0:0] {
        WAIT_FS  = 1'b0,
        IN_FRAME = 1'b1
    } state_e;

    // Assemble the per-frame trailer: {12'h0, truncated, len_err, dt_err, frame_ovf, line_count}.
    function automatic logic [31:0] make_trailer(
        input logic        truncated,
        input logic        len_err,
        input logic        dt_err,
        input logic        frame_ovf,
        input logic [15:0] line_count
    );
        logic [31:0] word;
        word                    = 32'h0000_0000;
        word[15:0]              = line_count;
        word[TRL_FRAME_OVF_BIT] = frame_ovf;
        word[TRL_DT_ERR_BIT]    = dt_err;
        word[TRL_LEN_ERR_BIT]   = len_err;
        word[TRL_TRUNC_BIT]     = truncated;
        return word;
    endfunction

endpackage

// File: rtl/svr_pixel_packer_if.sv
// -----------------------------------------------------------------------------
// svr_pixel_packer_if
// Packed-word output stream towards the frame-buffer writer.
//   out_data  : 32-bit packed word
//   out_valid : a word is available
//   out_ready : sink accepts the word this cycle
//   out_sop   : first word of a frame
//   out_eop   : trailer word (last of a frame)
// master = packer side, slave = frame-buffer writer side.
// -----------------------------------------------------------------------------
interface svr_pixel_packer_if;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;

    modport master (
        output out_data,
        output out_valid,
        output out_sop,
        output out_eop,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_sop,
        input  out_eop,
        output out_ready
    );
endinterface

// File: rtl/svr_sync_fifo.sv
// -----------------------------------------------------------------------------
// svr_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// head while empty is low; a pop advances to the next entry. A push while
// full is accepted only when a pop happens in the same cycle.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push/data   : write request and entry
//   pop         : consume head entry (ignored when empty)
//   head        : current head entry (zero when empty)
//   full/empty  : occupancy flags
//   level       : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module svr_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             accept_s;

    assign full_s   = (level_r == DEPTH_L);
    assign empty_s  = (level_r == '0);
    assign pop_s    = pop & ~empty_s;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign accept_s = push & (~full_s | pop_s);

    assign head  = empty_s ? '0 : mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign level = level_r;

    // Storage array write port; contents need no reset since head is gated by empty.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({accept_s, pop_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/svr_pixel_packer.sv
// -----------------------------------------------------------------------------
// svr_pixel_packer
// Packs the CSI-2 receiver pixel stream into 32-bit words (RAW10: 3 px/word,
// RAW8: 4 px/word, each line starts a fresh word), appends a trailer word per
// frame and buffers everything in a FWFT FIFO feeding a valid/ready stream.
//   fclk, reset_n     : clock, asynchronous active-low reset
//   enable            : capture enable, sampled at svr_fs only
//   expected_cols     : expected pixels per line (len_err check)
//   clear_sticky      : clears the sticky overflow flag
//   svr_pixel/_valid  : pixel data and qualifier
//   svr_fs/fe/ls/le   : frame/line start/end strobes
//   svr_data_type     : 0x2B RAW10, 0x28 RAW8, latched at svr_fs
//   out_if            : packed-word stream (data/valid/ready/sop/eop)
//   overflow          : sticky, an entry was dropped on a full FIFO
//   frame_count       : trailers accepted into the FIFO (wrapping)
//   fifo_level        : FIFO occupancy
// -----------------------------------------------------------------------------
module svr_pixel_packer
    import svr_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int AW         = 6
) (
    input  logic                      fclk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [15:0]               expected_cols,
    input  logic                      clear_sticky,
    input  logic [9:0]                svr_pixel,
    input  logic                      svr_pixel_valid,
    input  logic                      svr_fs,
    input  logic                      svr_fe,
    input  logic                      svr_ls,
    input  logic                      svr_le,
    input  logic [5:0]                svr_data_type,
    svr_pixel_packer_if.master        out_if,
    output logic                      overflow,
    output logic [15:0]               frame_count,
    output logic [AW:0]               fifo_level
);

    // Frame state and registered flags
    state_e      state_r;
    logic [5:0]  dt_r;
    logic [31:0] acc_r;
    logic [1:0]  k_r;
    logic [15:0] line_pix_r;
    logic [15:0] line_count_r;
    logic        len_err_r;
    logic        dt_err_r;
    logic        frame_ovf_r;
    logic        pending_sop_r;
    logic        overflow_r;
    logic [15:0] frame_count_r;

    // Combinational next-state and push request
    logic        dt_ok_s;
    logic        new_dt_bad_s;
    logic [1:0]  lane_last_s;
    logic [1:0]  k_base_s;
    logic [31:0] acc_base_s;
    logic [31:0] lane_word_s;
    logic [31:0] acc_nxt_s;
    logic [1:0]  k_nxt_s;
    logic [15:0] line_pix_nxt_s;
    logic        line_end_s;
    logic        len_bad_s;
    logic        push_s;
    logic [33:0] push_entry_s;
    logic        pop_s;
    logic        drop_s;

    // FIFO status
    logic [33:0] fifo_head_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic [AW:0] fifo_level_s;

    // Lane geometry for the data type latched at frame start.
    always_comb begin
        dt_ok_s     = 1'b0;
        lane_last_s = 2'd0;
        case (dt_r)
            DT_RAW10: begin
                dt_ok_s     = 1'b1;
                lane_last_s = 2'd2;
            end
            DT_RAW8: begin
                dt_ok_s     = 1'b1;
                lane_last_s = 2'd3;
            end
            default: begin
                dt_ok_s     = 1'b0;
                lane_last_s = 2'd0;
            end
        endcase
    end

    assign new_dt_bad_s = (svr_data_type != DT_RAW10) && (svr_data_type != DT_RAW8);

    // A line start restarts the word before a same-cycle pixel is placed.
    assign k_base_s   = svr_ls ? 2'd0 : k_r;
    assign acc_base_s = svr_ls ? 32'h0000_0000 : acc_r;

    // Place the incoming pixel into its lane of the word.
    always_comb begin
        if (dt_r == DT_RAW10) begin
            lane_word_s = {22'h00_0000, svr_pixel} << ({3'b000, k_base_s} * 5'd10);
        end else begin
            lane_word_s = {24'h00_0000, svr_pixel[7:0]} << {k_base_s, 3'b000};
        end
    end

    // Packing datapath: decides the single push of this cycle and next accumulator state.
    always_comb begin
        acc_nxt_s      = acc_r;
        k_nxt_s        = k_r;
        line_pix_nxt_s = line_pix_r;
        line_end_s     = 1'b0;
        len_bad_s      = 1'b0;
        push_s         = 1'b0;
        push_entry_s   = 34'h0_0000_0000;
        if (state_r == IN_FRAME) begin
            if (svr_fs) begin
                // New frame cuts the current one short: partial word is discarded.
                push_s       = 1'b1;
                push_entry_s = {pending_sop_r, 1'b1,
                                make_trailer(1'b1, len_err_r, dt_err_r, frame_ovf_r, line_count_r)};
            end else if (svr_fe) begin
                push_s       = 1'b1;
                push_entry_s = {pending_sop_r, 1'b1,
                                make_trailer(1'b0, len_err_r, dt_err_r, frame_ovf_r, line_count_r)};
            end else begin
                acc_nxt_s      = acc_base_s;
                k_nxt_s        = k_base_s;
                line_pix_nxt_s = svr_ls ? 16'h0000 : line_pix_r;
                if (svr_pixel_valid) begin
                    line_pix_nxt_s = line_pix_nxt_s + 16'd1;
                    if (dt_ok_s) begin
                        if (k_base_s == lane_last_s) begin
                            push_s       = 1'b1;
                            push_entry_s = {pending_sop_r, 1'b0, acc_base_s | lane_word_s};
                            acc_nxt_s    = 32'h0000_0000;
                            k_nxt_s      = 2'd0;
                        end else begin
                            acc_nxt_s = acc_base_s | lane_word_s;
                            k_nxt_s   = k_base_s + 2'd1;
                        end
                    end else begin
                        acc_nxt_s = acc_base_s;
                        k_nxt_s   = k_base_s;
                    end
                end else begin
                    line_pix_nxt_s = line_pix_nxt_s;
                end
                if (svr_le) begin
                    // A word completed by a same-cycle pixel already covers the flush.
                    if (!push_s && (k_nxt_s != 2'd0)) begin
                        push_s       = 1'b1;
                        push_entry_s = {pending_sop_r, 1'b0, acc_nxt_s};
                    end else begin
                        push_s = push_s;
                    end
                    acc_nxt_s  = 32'h0000_0000;
                    k_nxt_s    = 2'd0;
                    line_end_s = 1'b1;
                    len_bad_s  = (line_pix_nxt_s != expected_cols);
                end else begin
                    line_end_s = 1'b0;
                end
            end
        end else begin
            push_s = 1'b0;
        end
    end

    assign pop_s  = ~fifo_empty_s & out_if.out_ready;
    assign drop_s = push_s & fifo_full_s & ~pop_s;

    svr_sync_fifo #(
        .WIDTH (34),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (fclk),
        .rst_n     (reset_n),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level_s)
    );

    // Frame FSM with all frame-scoped registers, sticky overflow and frame counter.
    always_ff @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= WAIT_FS;
            dt_r          <= 6'h00;
            acc_r         <= 32'h0000_0000;
            k_r           <= 2'd0;
            line_pix_r    <= 16'h0000;
            line_count_r  <= 16'h0000;
            len_err_r     <= 1'b0;
            dt_err_r      <= 1'b0;
            frame_ovf_r   <= 1'b0;
            pending_sop_r <= 1'b0;
            overflow_r    <= 1'b0;
            frame_count_r <= 16'h0000;
        end else begin
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clear_sticky) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end

            if (push_s && push_entry_s[32] && !drop_s) begin
                frame_count_r <= frame_count_r + 16'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end

            if (svr_fs) begin
                // Frame start in either state; an ongoing frame already got its trailer.
                if (enable) begin
                    state_r       <= IN_FRAME;
                    dt_r          <= svr_data_type;
                    dt_err_r      <= new_dt_bad_s;
                    acc_r         <= 32'h0000_0000;
                    k_r           <= 2'd0;
                    line_pix_r    <= 16'h0000;
                    line_count_r  <= 16'h0000;
                    len_err_r     <= 1'b0;
                    frame_ovf_r   <= 1'b0;
                    pending_sop_r <= 1'b1;
                end else begin
                    state_r       <= WAIT_FS;
                    pending_sop_r <= 1'b0;
                end
            end else begin
                case (state_r)
                    WAIT_FS: begin
                        state_r <= WAIT_FS;
                    end
                    IN_FRAME: begin
                        if (svr_fe) begin
                            state_r       <= WAIT_FS;
                            pending_sop_r <= 1'b0;
                        end else begin
                            state_r    <= IN_FRAME;
                            acc_r      <= acc_nxt_s;
                            k_r        <= k_nxt_s;
                            line_pix_r <= line_pix_nxt_s;
                            if (line_end_s && (line_count_r != 16'hFFFF)) begin
                                line_count_r <= line_count_r + 16'd1;
                            end else begin
                                line_count_r <= line_count_r;
                            end
                            if (len_bad_s) begin
                                len_err_r <= 1'b1;
                            end else begin
                                len_err_r <= len_err_r;
                            end
                            if (drop_s) begin
                                frame_ovf_r <= 1'b1;
                            end else begin
                                frame_ovf_r <= frame_ovf_r;
                            end
                            if (push_s) begin
                                pending_sop_r <= 1'b0;
                            end else begin
                                pending_sop_r <= pending_sop_r;
                            end
                        end
                    end
                    default: begin
                        state_r <= WAIT_FS;
                    end
                endcase
            end
        end
    end

    assign out_if.out_data  = fifo_head_s[31:0];
    assign out_if.out_eop   = fifo_head_s[32];
    assign out_if.out_sop   = fifo_head_s[33];
    assign out_if.out_valid = ~fifo_empty_s;
    assign overflow         = overflow_r;
    assign frame_count      = frame_count_r;
    assign fifo_level       = fifo_level_s;

endmodule

// File: doc/svr_pixel_packer.md
Name: svr_pixel_packer

Overview:
- Consumes the fclk-domain video stream from the CSI-2 receiver (svr_pixel/svr_pixel_valid plus fs/fe/ls/le strobes and data type).
- Packs RAW10 pixels 3 per word and RAW8 pixels 4 per word into 32-bit words, keeping every line word-aligned.
- Appends a per-frame trailer word and buffers all words in a FIFO.
- Presents a valid/ready stream with sop/eop to the frame-buffer writer.

Parameters:
- FIFO_DEPTH, 64, FIFO entries (power of 2, ≥4); each entry is 34 bits: {sop, eop, data[31:0]}.
- AW, 6, log2(FIFO_DEPTH).

Ports:
- fclk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  capture enable, sampled only at svr_fs
- expected_cols  in  16  expected pixels per line
- clear_sticky  in  1  one-cycle pulse, clears overflow
- svr_pixel  in  10  pixel data
- svr_pixel_valid  in  1  pixel qualifier
- svr_fs / svr_fe / svr_ls / svr_le  in  1 each  one-cycle strobes
- svr_data_type  in  6  0x2B RAW10, 0x28 RAW8
- out_data  out  32  packed word
- out_valid  out  1  FIFO not empty
- out_ready  in  1  sink accept
- out_sop  out  1  first word of frame
- out_eop  out  1  trailer word
- overflow  out  1  sticky, a push was dropped
- frame_count  out  16  completed trailers pushed, wraps at 0xFFFF→0
- fifo_level  out  AW+1  occupancy

Behaviour:
- Reset: state WAIT_FS; accumulator, lane index k, and counters are 0; all outputs 0.
- States:
  - WAIT_FS: on svr_fs with enable=1 → IN_FRAME. On entry: latch dt, set pending_sop, clear frame flags and line_count. svr_fe/ls/le/pixels ignored.
  - IN_FRAME: packs pixels.
    - svr_fe → push trailer, then WAIT_FS.
    - svr_fs → discard partial word, push trailer with truncated flag. Stay IN_FRAME, re-initialised as a new frame (dt re-latched, pending_sop set); uses the enable value sampled at that fs.
- Latched dt: 0x2B → N=3, lane width 10; 0x28 → N=4, lane width 8.
  - Any other dt: pixels ignored, dt_err flag set, trailer still produced.
- Pixel (IN_FRAME, svr_pixel_valid):
  - Written to bits [W*k+W-1 : W*k]; RAW8 uses svr_pixel[7:0].
  - line_pix increments.
  - If k==N-1: push word, k←0, accumulator←0.
  - Unused bits (RAW10 [31:30]) are 0.
- svr_ls: line_pix←0, k←0.
- svr_le:
  - If k>0, push partial word (zero-filled), k←0.
  - If line_pix≠expected_cols, set len_err.
  - line_count increments (16-bit, saturating).
  - A pixel on the same cycle is included first. If that pixel completes a word, only that word is pushed.
  - At most one push per cycle by construction.
- Trailer word = {12'h0, truncated, len_err, dt_err, frame_ovf, line_count[15:0]} with eop=1. On trailer push, frame_count increments.
- sop: attached to the first push after frame start, then pending_sop clears. An empty frame gives a trailer with sop=1, eop=1.
- FIFO: first-word fall-through, out_* driven directly from head entry. Pop when out_valid & out_ready.
  - Push with full FIFO and no simultaneous pop: entry dropped, overflow←1, frame_ovf←1.
  - Push with full FIFO and simultaneous pop: accepted, level unchanged.
- overflow clears on clear_sticky unless a drop happens the same cycle (set wins).
- Latency: completing pixel at cycle t → out_valid at t+1 when the FIFO was empty.
- Reset mid-frame: FIFO emptied, state WAIT_FS, partial frame lost, no trailer.

Decomposition:
- Shared package svr_pkg: DT_RAW8=6'h28, DT_RAW10=6'h2B, trailer flag bit indices, state enum {WAIT_FS, IN_FRAME}.
- Sub-module svr_sync_fifo: single-clock, parameterised width/depth, FWFT, full/empty/level outputs.

Test Plan:
- RAW10, expected_cols=6, 2 lines of 6 px 1..6, out_ready=1 → 4 data words, first 0x0030_0801 with sop. Trailer 0x0000_0002 with eop; frame_count=1.
- RAW8, 5 px per line, expected_cols=4 → words 0x04030201 and 0x00000005. Trailer bit18 (len_err) set.
- out_ready=0, FIFO_DEPTH=4, 6 words pushed → fifo_level=4, overflow=1, trailer dropped. clear_sticky → overflow=0.
- svr_fs during IN_FRAME after 1 line → trailer with bit19=1, line_count=1. Next data word carries sop.
- svr_fs with enable=0, then lines and svr_fe → no output words, frame_count unchanged.
- dt=0x2C frame with 1 line → single word with sop=eop=1, bit17 set, line_count=1.
